// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: op codes,
// exception codes, FSM encoding, byte-lane constants and op classifiers.
package mem_access_defs;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_ADEL = 2'd1,
    EXC_ADES = 2'd2,
    EXC_BUS  = 2'd3
  } exc_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Big-endian lanes: byte offset 0 lives in sel[3] / data[31:24].
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H2 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = off[0];
      OP_LW, OP_SW:         r = (off != 2'b00);
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: select generation plus either store-data
// replication (LOAD=0) or load extraction with sign/zero extension (LOAD=1).
module mem_lane_align
  import mem_access_defs::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] din,
  output logic [3:0]  sel,
  output logic [31:0] dout
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and data positioning for one access.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    sel    = 4'b0000;
    dout   = 32'h0000_0000;
    case (offset)
      2'd0:    byte_s = din[31:24];
      2'd1:    byte_s = din[23:16];
      2'd2:    byte_s = din[15:8];
      default: byte_s = din[7:0];
    endcase
    if (offset[1]) half_s = din[15:0];
    else           half_s = din[31:16];
    case (op)
      OP_LB, OP_LBU, OP_SB: sel = SEL_B0 >> offset;
      OP_LH, OP_LHU, OP_SH: sel = offset[1] ? SEL_H2 : SEL_H0;
      OP_LW, OP_SW:         sel = SEL_W;
      default:              sel = 4'b0000;
    endcase
    if (LOAD) begin
      case (op)
        OP_LB:   dout = {{24{byte_s[7]}}, byte_s};
        OP_LBU:  dout = {24'h00_0000, byte_s};
        OP_LH:   dout = {{16{half_s[15]}}, half_s};
        OP_LHU:  dout = {16'h0000, half_s};
        OP_LW:   dout = din;
        default: dout = 32'h0000_0000;
      endcase
    end else begin
      // Stores replicate the source across lanes; sel picks the live ones.
      case (op)
        OP_SB:   dout = {4{din[7:0]}};
        OP_SH:   dout = {2{din[15:0]}};
        OP_SW:   dout = din;
        default: dout = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one RAM-adapter transaction per
// pipeline memory op, stalls until it completes, and reports address/bus faults.
module mem_access_ctrl
  import mem_access_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        flush_i,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  output logic        ram_ce_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ready_i,
  output logic        stall_req_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        exc_o,
  output logic [1:0]  exc_code_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_r, state_nxt_s;
  logic [15:0] cnt_r;
  logic [3:0]  op_r;
  logic [1:0]  off_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [3:0]  sel_r;
  logic        ce_r, we_r, done_r, exc_to_r;

  logic        op_ld_s, op_st_s, mis_s;
  logic        issue_s, mis_exc_s, ready_s, timeout_s;
  logic [3:0]  st_sel_s, unused_ld_sel_s;
  logic [31:0] st_data_s, ld_data_s;

  mem_lane_align #(.LOAD(1'b0)) u_store_align (
    .op     (mem_op_i),
    .offset (mem_addr_i[1:0]),
    .din    (mem_wdata_i),
    .sel    (st_sel_s),
    .dout   (st_data_s)
  );

  mem_lane_align #(.LOAD(1'b1)) u_load_align (
    .op     (op_r),
    .offset (off_r),
    .din    (ram_data_i),
    .sel    (unused_ld_sel_s),
    .dout   (ld_data_s)
  );

  // Next-state decode; the cycle after a timeout never reissues the faulting op.
  always_comb begin
    op_ld_s     = is_load(mem_op_i);
    op_st_s     = is_store(mem_op_i);
    mis_s       = is_misaligned(mem_op_i, mem_addr_i[1:0]);
    issue_s     = 1'b0;
    mis_exc_s   = 1'b0;
    ready_s     = 1'b0;
    timeout_s   = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!rst || flush_i || exc_to_r || !mem_valid_i || !(op_ld_s || op_st_s)) begin
          state_nxt_s = ST_IDLE;
        end else if (mis_s) begin
          mis_exc_s = 1'b1;
        end else begin
          issue_s     = 1'b1;
          state_nxt_s = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush_i) begin
          state_nxt_s = ST_IDLE;
        end else if (ram_ready_i) begin
          ready_s     = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (cnt_r == TO_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched request, wait counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 16'd0;
      op_r     <= 4'd0;
      off_r    <= 2'd0;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      sel_r    <= 4'b0000;
      ce_r     <= 1'b0;
      we_r     <= 1'b0;
      done_r   <= 1'b0;
      exc_to_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      done_r   <= ready_s;
      exc_to_r <= timeout_s;
      if (issue_s) begin
        addr_r  <= {mem_addr_i[31:2], 2'b00};
        we_r    <= op_st_s;
        sel_r   <= st_sel_s;
        wdata_r <= st_data_s;
        op_r    <= mem_op_i;
        off_r   <= mem_addr_i[1:0];
        ce_r    <= 1'b1;
        cnt_r   <= 16'd0;
      end else if ((state_r == ST_REQ) && (state_nxt_s == ST_REQ)) begin
        ce_r    <= 1'b1;
        cnt_r   <= cnt_r + 16'd1;
      end else begin
        ce_r    <= 1'b0;
        cnt_r   <= 16'd0;
      end
      if (ready_s) rdata_r <= we_r ? 32'h0000_0000 : ld_data_s;
      else         rdata_r <= rdata_r;
    end
  end

  // Stall and exception outputs; misalignment is reported in the issuing cycle.
  always_comb begin
    stall_req_o = (state_r == ST_REQ) || issue_s;
    exc_o       = exc_to_r || mis_exc_s;
    if (exc_to_r)       exc_code_o = EXC_BUS;
    else if (mis_exc_s) exc_code_o = op_st_s ? EXC_ADES : EXC_ADEL;
    else                exc_code_o = EXC_NONE;
  end

  assign ram_addr_o = addr_r;
  assign ram_we_o   = we_r;
  assign ram_sel_o  = sel_r;
  assign ram_data_o = wdata_r;
  assign ram_ce_o   = ce_r;
  assign done_o     = done_r;
  assign rdata_o    = rdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and random memory ops
// against a lane/extension model built from plain shifts and masks.
module tb_mem_access_ctrl;
  import mem_access_defs::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_i = 1'b0;
  logic [3:0]  mem_op_i = 4'd0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_wdata_i = 32'd0;
  logic        flush_i = 1'b0;
  logic [31:0] ram_addr_o;
  logic        ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic        ram_ce_o;
  logic [31:0] ram_data_i = 32'd0;
  logic        ram_ready_i = 1'b0;
  logic        stall_req_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        exc_o;
  logic [1:0]  exc_code_o;
  logic [5:0]  ctl;

  int n_vec = 0;
  int n_err = 0;

  assign ctl = {ram_ce_o, stall_req_o, done_o, exc_o, exc_code_o};

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o), .ram_ce_o(ram_ce_o), .ram_data_i(ram_data_i),
    .ram_ready_i(ram_ready_i), .stall_req_o(stall_req_o), .done_o(done_o),
    .rdata_o(rdata_o), .exc_o(exc_o), .exc_code_o(exc_code_o)
  );

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [1:0] off);
    int o;
    o = int'(off);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return 4'(32'd1 << (3 - o));
    else if (op inside {OP_LH, OP_LHU, OP_SH}) return (o == 0) ? 4'hC : 4'h3;
    else if (op inside {OP_LW, OP_SW}) return 4'hF;
    else return 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
    if (op == OP_SB) return (w & 32'hFF) * 32'h0101_0101;
    else if (op == OP_SH) return (w & 32'hFFFF) * 32'h0001_0001;
    else if (op == OP_SW) return w;
    else return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [1:0] off, input logic [31:0] word);
    logic [31:0] b, h;
    int o;
    o = int'(off);
    b = (word >> (8 * (3 - o))) & 32'hFF;
    h = (word >> (8 * (2 - o))) & 32'hFFFF;
    if (op == OP_LB)       return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
    else if (op == OP_LBU) return b;
    else if (op == OP_LH)  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
    else if (op == OP_LHU) return h;
    else if (op == OP_LW)  return word;
    else return 32'h0;
  endfunction

  task automatic settle_idle();
    @(negedge clk);
    mem_valid_i = 1'b0; ram_ready_i = 1'b0; flush_i = 1'b0;
    #1;
    n_vec++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL idle ctl act=%b exp=000000", ctl);
    end
  endtask

  // wait_n: REQ cycle in which ready is given (0 = never); flush_at: REQ cycle of flush (0 = none)
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] word, input int wait_n, input int flush_at, input bit settle);
    bit ld, st, mis;
    logic [1:0] off;
    logic [5:0] exp_ctl;
    logic [31:0] e_rdata;
    int outcome, ce_cnt, exp_ce;
    off = addr[1:0];
    ld  = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    st  = op inside {OP_SB, OP_SH, OP_SW};
    mis = ((op inside {OP_LH, OP_LHU, OP_SH}) && (off % 2 == 1)) ||
          ((op inside {OP_LW, OP_SW}) && (off != 2'd0));
    e_rdata = st ? 32'h0 : m_load(op, off, word);

    @(negedge clk);
    mem_valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
    flush_i = 1'b0; ram_ready_i = 1'b0; ram_data_i = $urandom;
    #1;
    if (!ld && !st)  exp_ctl = 6'b000000;
    else if (mis)    exp_ctl = {4'b0001, st ? 2'd2 : 2'd1};
    else             exp_ctl = 6'b010000;
    n_vec++;
    if (ctl !== exp_ctl) begin
      n_err++; $display("FAIL issue op=%0d addr=%h ctl act=%b exp=%b", op, addr, ctl, exp_ctl);
    end
    if ((!ld && !st) || mis) begin
      if (settle) settle_idle();
      return;
    end

    outcome = -1;
    ce_cnt  = 0;
    for (int cyc = 1; cyc <= TO && outcome < 0; cyc++) begin
      @(negedge clk);
      ram_ready_i = (wait_n != 0) && (cyc >= wait_n);
      ram_data_i  = ram_ready_i ? word : $urandom;
      flush_i     = (cyc == flush_at);
      #1;
      n_vec++;
      if ({ctl, ram_addr_o, ram_we_o, ram_sel_o} !== {6'b110000, addr & 32'hFFFF_FFFC, st, m_sel(op, off)}) begin
        n_err++;
        $display("FAIL req cyc=%0d act ctl=%b addr=%h we=%b sel=%b exp ctl=110000 addr=%h we=%b sel=%b",
                 cyc, ctl, ram_addr_o, ram_we_o, ram_sel_o, addr & 32'hFFFF_FFFC, st, m_sel(op, off));
      end
      if (st) begin
        n_vec++;
        if (ram_data_o !== m_wdata(op, wdata)) begin
          n_err++; $display("FAIL store_data act=%h exp=%h", ram_data_o, m_wdata(op, wdata));
        end
      end
      if (ram_ce_o === 1'b1) ce_cnt++;
      if (flush_i) outcome = 2;
      else if (ram_ready_i) outcome = 0;
      else if (cyc == TO) outcome = 1;
    end

    @(negedge clk);
    ram_ready_i = 1'b0; flush_i = 1'b0;
    if (outcome == 2) mem_valid_i = 1'b0;
    #1;
    exp_ctl = (outcome == 0) ? 6'b001000 : (outcome == 1) ? 6'b000111 : 6'b000000;
    n_vec++;
    if (ctl !== exp_ctl) begin
      n_err++; $display("FAIL outcome=%0d ctl act=%b exp=%b", outcome, ctl, exp_ctl);
    end
    if (outcome == 0) begin
      n_vec++;
      if (rdata_o !== e_rdata) begin
        n_err++; $display("FAIL rdata op=%0d addr=%h act=%h exp=%h", op, addr, rdata_o, e_rdata);
      end
    end
    exp_ce = (outcome == 0) ? wait_n : (outcome == 1) ? TO : flush_at;
    n_vec++;
    if (ce_cnt !== exp_ce) begin
      n_err++; $display("FAIL ce_cycles act=%0d exp=%0d", ce_cnt, exp_ce);
    end
    if (settle) settle_idle();
  endtask

  task automatic test_reset();
    mem_valid_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 32'h100;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({ctl, ram_addr_o, ram_we_o, ram_sel_o, ram_data_o, rdata_o} !== 108'd0) begin
      n_err++; $display("FAIL reset ctl=%b addr=%h sel=%b data=%h rdata=%h exp all zero",
                        ctl, ram_addr_o, ram_sel_o, ram_data_o, rdata_o);
    end
    @(negedge clk);
    mem_valid_i = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_directed();
    run_access(OP_LW,  32'h0000_0100, 32'h0, 32'h1122_3344, 3, 0, 1'b1);
    run_access(OP_LB,  32'h0000_0103, 32'h0, 32'h0000_00F0, 2, 0, 1'b1);
    run_access(OP_LBU, 32'h0000_0103, 32'h0, 32'h0000_00F0, 1, 0, 1'b1);
    run_access(OP_LH,  32'h0000_0200, 32'h0, 32'h8001_7FFF, 2, 0, 1'b1);
    run_access(OP_LHU, 32'h0000_0202, 32'h0, 32'h1234_ABCD, 1, 0, 1'b1);
    run_access(OP_SH,  32'h0000_0202, 32'h0000_BEEF, 32'h0, 2, 0, 1'b1);
    run_access(OP_SB,  32'h0000_0301, 32'h1234_56A5, 32'h0, 1, 0, 1'b1);
  endtask

  task automatic test_misaligned();
    run_access(OP_LW,  32'h0000_0101, 32'h0, 32'h0, 1, 0, 1'b1);
    run_access(OP_SW,  32'h0000_0102, 32'h0, 32'h0, 1, 0, 1'b1);
    run_access(OP_LHU, 32'h0000_0103, 32'h0, 32'h0, 1, 0, 1'b1);
    run_access(OP_SH,  32'h0000_0101, 32'h0, 32'h0, 1, 0, 1'b1);
  endtask

  task automatic test_timeout();
    run_access(OP_LW, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b1);
    run_access(OP_LW, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, TO, 0, 1'b1);
  endtask

  task automatic test_flush();
    run_access(OP_LW, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 3, 1, 1'b1);
    run_access(OP_LB, 32'h0000_0502, 32'h0, 32'h5555_AAAA, 2, 2, 1'b1);
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_valid_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 32'h0000_0600; ram_ready_i = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (ram_ce_o !== 1'b1) begin
      n_err++; $display("FAIL midreq_ce act=%b exp=1", ram_ce_o);
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({ctl, ram_addr_o, ram_we_o, ram_sel_o, ram_data_o, rdata_o} !== 108'd0) begin
      n_err++; $display("FAIL midreq_reset ctl=%b addr=%h sel=%b exp all zero", ctl, ram_addr_o, ram_sel_o);
    end
    @(negedge clk);
    mem_valid_i = 1'b0;
    rst = 1'b1;
    settle_idle();
  endtask

  task automatic test_back_to_back();
    run_access(OP_SW, 32'h0000_0700, 32'hA1B2_C3D4, 32'h0, 1, 0, 1'b0);
    run_access(OP_LW, 32'h0000_0700, 32'h0, 32'hA1B2_C3D4, 1, 0, 1'b0);
    run_access(OP_LH, 32'h0000_0702, 32'h0, 32'hA1B2_C3D4, 2, 0, 1'b0);
    run_access(OP_LW, 32'h0000_0704, 32'h0, 32'h0, 0, 0, 1'b0);
    run_access(OP_SB, 32'h0000_0707, 32'h0000_0099, 32'h0, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    int wait_n, flush_at, r;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 8));
      r = $urandom_range(0, 9);
      wait_n = (r == 0) ? 0 : 1 + (r % 4);
      flush_at = 0;
      if ((op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW}) && ($urandom_range(0, 5) == 0))
        flush_at = $urandom_range(1, 3);
      run_access(op, $urandom, $urandom, $urandom, wait_n, flush_at, 1'($urandom_range(0, 1)));
    end
    settle_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_timeout();
    test_flush();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
